// File: rtl/pwm_cmd_scheduler.sv
// PWM command scheduler: synchronises SPI command words, queues them, decodes them
// into shadow state and streams committed compare values out at a period boundary.
module pwm_cmd_scheduler #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned CMP_W      = 8,
  parameter int unsigned DIV_W      = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cmd_data,
  input  logic              cmd_rdy,
  input  logic              period_end,
  output logic [CMP_W-1:0]  compare_out,
  output logic [NUM_CH-1:0] ch_wr,
  output logic [NUM_CH-1:0] ch_en,
  output logic [DIV_W-1:0]  div_out,
  output logic              div_wr,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FW = 5 + CMP_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_UPDATE
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE_CMP = 2'b00,
    OP_SET_DIV   = 2'b01,
    OP_ENABLE    = 2'b10,
    OP_COMMIT    = 2'b11
  } opcode_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q, sync3_q;
  logic [FW-1:0]      fifo_q [FIFO_DEPTH];
  logic [FW-1:0]      fifo_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CMP_W-1:0]   shadow_q [NUM_CH];
  logic [CMP_W-1:0]   shadow_d [NUM_CH];
  logic [NUM_CH-1:0]  dirty_q, dirty_d;
  logic [NUM_CH-1:0]  ch_en_q, ch_en_d;
  logic [NUM_CH-1:0]  ch_wr_q, ch_wr_d;
  logic [CMP_W-1:0]   cmp_q, cmp_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               div_wr_q, div_wr_d;
  logic               ovf_q, ovf_d;

  logic               push, pop, full, push_ok;
  logic [FW-1:0]      head;
  logic [2:0]         head_ch;
  opcode_t            head_op;
  logic [CMP_W-1:0]   head_pl;
  logic [NUM_CH-1:0]  sel_oh;
  logic [CMP_W-1:0]   sel_cmp;

  assign push    = sync2_q & ~sync3_q;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  // a full FIFO still takes a push when the same cycle pops
  assign push_ok = push & (~full | pop);
  assign head    = fifo_q[rd_ptr_q];
  assign head_ch = head[FW-1 -: 3];
  assign head_op = opcode_t'(head[FW-4 -: 2]);
  assign head_pl = head[CMP_W-1:0];
  assign sel_oh  = dirty_q & (~dirty_q + NUM_CH'(1));

  always_comb begin
    sel_cmp = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sel_cmp = sel_cmp | (shadow_q[i] & {CMP_W{sel_oh[i]}});
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    ch_en_d  = ch_en_q;
    ch_wr_d  = '0;
    cmp_d    = cmp_q;
    div_d    = div_q;
    div_wr_d = 1'b0;
    ovf_d    = ovf_q | (push & ~push_ok);

    if (push_ok) begin
      fifo_d[wr_ptr_q] = {cmd_data[15:11], cmd_data[CMP_W-1:0]};
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          case (head_op)
            OP_WRITE_CMP: begin
              for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (3'(i) == head_ch) begin
                  shadow_d[i] = head_pl;
                  dirty_d[i]  = 1'b1;
                end
              end
            end
            OP_SET_DIV: begin
              div_d    = head_pl[DIV_W-1:0];
              div_wr_d = 1'b1;
            end
            OP_ENABLE: begin
              for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (3'(i) == head_ch) begin
                  ch_en_d[i] = head_pl[0];
                end
              end
            end
            default: begin
              if (dirty_q != '0) state_d = S_WAIT;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (period_end) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        ch_wr_d = sel_oh;
        if (sel_oh != '0) cmp_d = sel_cmp;
        dirty_d = dirty_q & ~sel_oh;
        if (dirty_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      sync3_q  <= 1'b1;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      dirty_q  <= '0;
      ch_en_q  <= '0;
      ch_wr_q  <= '0;
      cmp_q    <= '0;
      div_q    <= '0;
      div_wr_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= cmd_rdy;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
      ch_en_q  <= ch_en_d;
      ch_wr_q  <= ch_wr_d;
      cmp_q    <= cmp_d;
      div_q    <= div_d;
      div_wr_q <= div_wr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign compare_out = cmp_q;
  assign ch_wr       = ch_wr_q;
  assign ch_en       = ch_en_q;
  assign div_out     = div_q;
  assign div_wr      = div_wr_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: doc/pwm_cmd_scheduler.md
Name: pwm_cmd_scheduler

Overview:
- Sits between the SPI receiver and the bank of PWM generators.
- Captures 16-bit SPI command words and queues them in a small FIFO.
- Decodes each word into shadow compare registers, channel enables and the clock-divider setting.
- On COMMIT, waits for a PWM period boundary, then issues glitch-free compare updates over one shared compare bus, one channel per cycle.

Parameters:
NUM_CH, 8, number of PWM channels (channel field is 3 bits, so max 8)
CMP_W, 8, compare register width
DIV_W, 3, clock divider select width
FIFO_DEPTH, 4, command FIFO entries (power of 2)

Ports:
clk  in  1  single system clock
rst  in  1  synchronous reset, active high
cmd_data  in  16  SPI word; stable while cmd_rdy high; [15:13] channel, [12:11] opcode, [CMP_W-1:0] payload
cmd_rdy  in  1  SPI word-ready level, asynchronous to clk
period_end  in  1  one-cycle pulse from PWM timebase at counter wrap
compare_out  out  CMP_W  shared compare value bus, registered
ch_wr  out  NUM_CH  one-hot, one-cycle write strobe, registered
ch_en  out  NUM_CH  per-channel enable level
div_out  out  DIV_W  clock divider select
div_wr  out  1  one-cycle divider load strobe
busy  out  1  FSM not IDLE or FIFO non-empty
overflow  out  1  sticky; a command was dropped

Behaviour:
- Reset (rst sampled high at a clk edge):
  - compare_out, ch_wr, ch_en, div_out, div_wr, overflow = 0; busy = 0.
  - FIFO emptied; all shadow registers and dirty bits cleared; FSM to IDLE.
  - Reset mid-WAIT or mid-UPDATE abandons the pending commit; no further ch_wr pulses.
- Input capture:
  - cmd_rdy passes through a 2-flop synchronizer plus an edge-detect flop; all three reset to 1, so a level held high across reset release is never captured.
  - Rising edge sampled at edge k: s1=1 at k, s2=1 at k+1, FIFO write at k+2.
  - FIFO full at write time: word dropped, overflow set (cleared only by rst).
- Pop and decode:
  - Allowed only in IDLE, one entry per cycle.
  - Push and pop in the same cycle are both honoured; a full FIFO that is popped in the same cycle accepts the push.
  - Empty FIFO in IDLE: effects occur at edge k+3.
- Opcodes:
  - 00 WRITE_CMP: shadow[ch] <= payload; dirty[ch] <= 1. A rewrite before COMMIT overwrites; last value wins.
  - 01 SET_DIV: div_out <= payload[DIV_W-1:0]; div_wr=1 for exactly one cycle; no commit needed.
  - 10 ENABLE: ch_en[ch] <= payload[0], applied immediately.
  - 11 COMMIT: if dirty==0, no-op and stay IDLE; else go to WAIT.
- FSM IDLE -> WAIT -> UPDATE -> IDLE:
  - WAIT: no pops. A period_end in the same cycle as the COMMIT pop is ignored. The first period_end sampled while in WAIT (edge j) moves to UPDATE.
  - UPDATE: each cycle, select the lowest-index set dirty bit i. Register compare_out=shadow[i] and ch_wr=1<<i, then clear dirty[i].
  - The first pulse is visible from edge j+1. N dirty channels produce N consecutive single-cycle pulses in ascending index order.
  - Return to IDLE in the cycle the last dirty bit clears; ch_wr=0 afterwards.
- Hold and queueing:
  - compare_out holds its last value between pulses.
  - Commands arriving during WAIT/UPDATE queue in the FIFO and are processed after the return to IDLE.
- Strobe rules: ch_wr is never multi-hot. div_wr and ch_wr may assert in the same cycle only if a SET_DIV pop coincides, which cannot happen because there are no pops outside IDLE.

Test Plan:
- Reset: assert rst 2 cycles with cmd_rdy held high, then release -> all outputs 0, busy=0, no word captured.
- WRITE_CMP ch3 payload 0x80, COMMIT, then period_end pulse -> exactly one cycle with ch_wr=0x08, compare_out=0x80, starting one edge after period_end is sampled; busy drops the next cycle.
- WRITE_CMP ch7=0x11, ch0=0x22, ch5=0x33, COMMIT, period_end -> three consecutive pulses ch_wr=0x01/0x20/0x80 with compare_out=0x22/0x33/0x11.
- SET_DIV payload 0x05 -> div_out=5 and div_wr high one cycle at k+3; ENABLE ch2 payload 1 -> ch_en=0x04.
- COMMIT with no dirty channels -> no WAIT, no ch_wr even after period_end. Rewrite ch1 with 0x10 then 0x20, then COMMIT -> single pulse with compare_out=0x20.
- WRITE_CMP + COMMIT, then 6 words sent before period_end -> 4 queued, overflow=1, 2 dropped. After the update, the queued 4 execute in order. rst during WAIT -> no ch_wr pulses and overflow cleared.
